// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, registers one instruction per
// unstalled cycle into ir, squashes one slot on taken branches, halts on kSTOP.
package fetch_defs_pkg;
  localparam logic [3:0] kSTOP = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2,
    ST_HALT     = 2'd3
  } fetch_state_e;
endpackage

module fetch_unit
  import fetch_defs_pkg::*;
#(
  parameter int PC_W     = 10,
  parameter int IW       = 9,
  parameter int START_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [IW-1:0]    imem_data,
  output logic [IW-1:0]    ir,
  output logic [PC_W-1:0]  ir_pc,
  output logic             ir_valid,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [PC_W-1:0] START_ADDR = PC_W'(START_PC);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic [PC_W-1:0]  ir_pc_q, ir_pc_d;
  logic             ir_valid_q, ir_valid_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       opcode;
  logic             is_stop;

  assign opcode  = imem_data[IW-1:IW-4];
  assign is_stop = (opcode == kSTOP);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    done_d     = done_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d       = START_ADDR;
          ir_valid_d = 1'b0;
          done_d     = 1'b0;
          cnt_d      = '0;
          state_d    = ST_RUN;
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!stall) begin
          if (branch_taken) begin
            // The word fetched at the old pc this cycle is dropped, kSTOP included.
            pc_d       = branch_target;
            ir_valid_d = 1'b0;
          end else begin
            ir_d       = imem_data;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            if (is_stop) begin
              state_d = ST_STOPPING;
            end else begin
              pc_d = pc_q + PC_W'(1);
            end
          end
        end
      end

      ST_STOPPING: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!stall) begin
          ir_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = ST_HALT;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= START_ADDR;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign done        = done_q;
  assign cycle_count = cnt_q;

endmodule
